// File: rtl/rgb_pwm_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pwm_pkg
// Shared definitions for the RGB PWM LED driver: channel mode encoding,
// width of the blink/breathe period field and width of the channel index.
// -----------------------------------------------------------------------------
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } pwm_mode_e;

    // Frames per blink half-period / breathe step, minus one.
    localparam int PERIOD_W = 8;

    // Channel index width on the configuration port.
    localparam int CHAN_W = 3;

endpackage

// File: rtl/rgb_pwm_chan.sv
// -----------------------------------------------------------------------------
// rgb_pwm_chan
// One LED channel: mode engine (OFF / STATIC / BLINK / BREATHE) that updates the
// brightness level once per frame, plus the registered PWM comparator.
//
// Ports
//   clk48        in   clock
//   rst          in   synchronous active-high reset
//   frame_adv    in   strobe in the last cycle of a frame; level changes on this edge
//   apply        in   load new configuration on this frame boundary
//   apply_mode   in   mode to load
//   apply_duty   in   target brightness to load
//   apply_period in   frames per blink half-period / breathe step, minus one
//   pwm_cnt      in   shared PWM step counter
//   led_n        out  active-low LED drive (registered)
// -----------------------------------------------------------------------------
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk48,
    input  logic                rst,
    input  logic                frame_adv,
    input  logic                apply,
    input  pwm_mode_e           apply_mode,
    input  logic [PWM_BITS-1:0] apply_duty,
    input  logic [PERIOD_W-1:0] apply_period,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_n
);

    pwm_mode_e           mode;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] level;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] frame_cnt;
    logic                phase_on;
    logic                dir_up;
    logic                period_done;
    logic [PWM_BITS-1:0] breathe_nxt;

    // Triangle-wave step for breathe mode.
    function automatic logic [PWM_BITS-1:0] breathe_step(input logic [PWM_BITS-1:0] lvl,
                                                         input logic                up);
        return up ? lvl + 1'b1 : lvl - 1'b1;
    endfunction

    assign period_done = (frame_cnt == period);
    assign breathe_nxt = breathe_step(level, dir_up);

    // Configuration data registers carry no reset; mode decides their use.
    always_ff @(posedge clk48) begin
        if (frame_adv && apply) begin
            duty   <= apply_duty;
            period <= apply_period;
        end
    end

    // Mode engine: level only moves on the frame boundary so every frame is
    // driven with a single, constant level.
    always_ff @(posedge clk48) begin
        if (rst) begin
            mode      <= MODE_OFF;
            level     <= '0;
            frame_cnt <= '0;
            phase_on  <= 1'b1;
            dir_up    <= 1'b1;
        end else if (frame_adv) begin
            if (apply) begin
                mode      <= apply_mode;
                frame_cnt <= '0;
                phase_on  <= 1'b1;
                dir_up    <= 1'b1;
                level     <= (apply_mode == MODE_STATIC || apply_mode == MODE_BLINK)
                             ? apply_duty : '0;
            end else begin
                frame_cnt <= period_done ? '0 : frame_cnt + 1'b1;
                if (period_done) begin
                    case (mode)
                        MODE_BLINK: begin
                            phase_on <= !phase_on;
                            level    <= phase_on ? '0 : duty;
                        end
                        MODE_BREATHE: begin
                            if (duty == '0) begin
                                level <= '0;
                            end else begin
                                level <= breathe_nxt;
                                if (breathe_nxt == duty)
                                    dir_up <= 1'b0;
                                else if (breathe_nxt == '0)
                                    dir_up <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Comparator stage: all-ones level means fully on, zero is never on.
    always_ff @(posedge clk48) begin
        if (rst)
            led_n <= 1'b1;
        else
            led_n <= !((&level) || (pwm_cnt < level));
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// -----------------------------------------------------------------------------
// rgb_pwm_driver
// Multi-channel PWM LED driver. A prescaler produces PWM steps, a shared step
// counter defines the frame, and a single-entry configuration shadow is applied
// to its target channel at the next frame boundary.
//
// Ports
//   clk48       in   48 MHz clock
//   rst         in   synchronous active-high reset
//   cfg_valid   in   configuration request
//   cfg_ready   out  configuration may be accepted
//   cfg_chan    in   target channel index (out-of-range requests are dropped)
//   cfg_mode    in   0 OFF, 1 STATIC, 2 BLINK, 3 BREATHE
//   cfg_duty    in   target brightness
//   cfg_period  in   frames per blink half-period / breathe step, minus one
//   led_n       out  active-low LED drive, bit i = channel i
//   frame_tick  out  one-cycle pulse at each frame start
// -----------------------------------------------------------------------------
module rgb_pwm_driver
    import rgb_pwm_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 188
) (
    input  logic                clk48,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic [CHANNELS-1:0] led_n,
    output logic                frame_tick
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     presc_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step;
    logic                frame_adv;
    logic                accept;
    logic                apply_any;
    logic                pending;

    logic [CHAN_W-1:0]   sh_chan;
    pwm_mode_e           sh_mode;
    logic [PWM_BITS-1:0] sh_duty;
    logic [PERIOD_W-1:0] sh_period;

    logic [CHAN_W-1:0]   ap_chan;
    pwm_mode_e           ap_mode;
    logic [PWM_BITS-1:0] ap_duty;
    logic [PERIOD_W-1:0] ap_period;

    assign step      = (presc_cnt == PS_LAST);
    // Last step of the frame: the edge that wraps pwm_cnt to 0.
    assign frame_adv = step && (&pwm_cnt);
    assign accept    = cfg_valid && cfg_ready;
    // A request accepted in the very last cycle of a frame bypasses the shadow
    // and still makes the upcoming frame.
    assign apply_any = frame_adv && (pending || accept);

    assign ap_chan   = pending ? sh_chan   : cfg_chan;
    assign ap_mode   = pending ? sh_mode   : pwm_mode_e'(cfg_mode);
    assign ap_duty   = pending ? sh_duty   : cfg_duty;
    assign ap_period = pending ? sh_period : cfg_period;

    always_ff @(posedge clk48) begin
        if (rst) begin
            presc_cnt  <= '0;
            pwm_cnt    <= '0;
            frame_tick <= 1'b0;
            pending    <= 1'b0;
            cfg_ready  <= 1'b0;
        end else begin
            presc_cnt  <= step ? '0 : presc_cnt + 1'b1;
            if (step)
                pwm_cnt <= pwm_cnt + 1'b1;
            frame_tick <= frame_adv;

            if (apply_any)
                pending <= 1'b0;
            else if (accept)
                pending <= 1'b1;

            // Ready returns one cycle after the frame_tick that consumed the
            // shadow, since pending is already clear during that cycle.
            if (accept)
                cfg_ready <= 1'b0;
            else if (!cfg_ready && !pending)
                cfg_ready <= 1'b1;
        end
    end

    // Shadow payload; validity is tracked by pending.
    always_ff @(posedge clk48) begin
        if (accept) begin
            sh_chan   <= cfg_chan;
            sh_mode   <= pwm_mode_e'(cfg_mode);
            sh_duty   <= cfg_duty;
            sh_period <= cfg_period;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic apply_i;
        assign apply_i = apply_any && (ap_chan == CHAN_W'(i));

        rgb_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk48        (clk48),
            .rst          (rst),
            .frame_adv    (frame_adv),
            .apply        (apply_i),
            .apply_mode   (ap_mode),
            .apply_duty   (ap_duty),
            .apply_period (ap_period),
            .pwm_cnt      (pwm_cnt),
            .led_n        (led_n[i])
        );
    end

endmodule
